// File: rtl/img_pkg.sv
// Purpose     : shared pixel type and line-buffer state encoding for the image front end.
// Latency     : n/a (types and constants only).
// Backpressure: n/a.
package img_pkg;

    localparam int PIX_W = 12;

    typedef logic [PIX_W-1:0] pix_t;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } lb_state_t;

endpackage : img_pkg

// File: rtl/line_ram.sv
// Purpose     : single-port DEPTH x W line memory, combinational read, read-before-write.
// Latency     : read is combinational; a write lands at the clock edge.
// Backpressure: none; one access per cycle.
//
// Ports:
//   clk     - clock
//   we_i    - write enable
//   addr_i  - shared read/write address
//   wdata_i - write data
//   rdata_o - current contents at addr_i (the old value on a write cycle)
module line_ram
    import img_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int W     = PIX_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o
);

    // Contents are deliberately not reset; row 0 always rewrites every entry
    // before anything reads it back as a previous row.
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule : line_ram

// File: rtl/bayer_line_buffer.sv
// Purpose     : one-line Bayer buffer; emits each 2x2 quad as (cur,prev) pairs on two cycles.
// Latency     : pair 0 and 1 cycle(s) after the odd-row/odd-col accept edge; gs_valid 2 cycles after it.
// Backpressure: none; one pixel per cycle is always accepted, bubbles allowed anywhere.
//
// Ports:
//   clk, rst_n       - clock, async active-low reset
//   pix_in/pix_valid - raster pixel stream; sof marks (row 0, col 0) when valid
//   row_cur/row_prev - current/previous row pixel of one quad column, qualified by pair_valid
//   gs_valid         - downstream averaging registers hold a full quad this cycle
//   gs_x/gs_y        - quad column/row of that result
module bayer_line_buffer
    import img_pkg::*;
#(
    parameter int DATA_W = PIX_W,
    parameter int LINE_W = 640,
    parameter int X_W    = $clog2(LINE_W / 2),
    parameter int Y_W    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    input  logic              sof,
    output logic [DATA_W-1:0] row_cur,
    output logic [DATA_W-1:0] row_prev,
    output logic              pair_valid,
    output logic              gs_valid,
    output logic [X_W-1:0]    gs_x,
    output logic [Y_W-1:0]    gs_y
);

    localparam int CW = X_W + 1;   // column counter width
    localparam int RW = Y_W + 1;   // row counter width (full row, not quad row)

    // ---------------------------------------------------------------
    // Raster counters. sof overrides the stored position for its own
    // pixel, so every downstream decision uses the *_eff view.
    // ---------------------------------------------------------------
    logic [CW-1:0] col_q, col_d, col_eff;
    logic [RW-1:0] row_q, row_d, row_eff;
    logic          trigger;

    always_comb begin
        col_eff = (pix_valid && sof) ? '0 : col_q;
        row_eff = (pix_valid && sof) ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (pix_valid) begin
            if (col_eff == CW'(LINE_W - 1)) begin
                col_d = '0;
                row_d = row_eff + 1'b1;
            end else begin
                col_d = col_eff + 1'b1;
                row_d = row_eff;
            end
        end
    end

    // Odd row + odd column completes a quad.
    assign trigger = pix_valid && row_eff[0] && col_eff[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // ---------------------------------------------------------------
    // Line memory: read at the current column returns the row above.
    // ---------------------------------------------------------------
    logic [DATA_W-1:0] mem_rd;

    line_ram #(
        .DEPTH (LINE_W),
        .W     (DATA_W),
        .AW    (CW)
    ) u_line_ram (
        .clk     (clk),
        .we_i    (pix_valid),
        .addr_i  (col_eff),
        .wdata_i (pix_in),
        .rdata_o (mem_rd)
    );

    // ---------------------------------------------------------------
    // Even-column hold: left half of the quad waits here for its odd partner.
    // ---------------------------------------------------------------
    logic [DATA_W-1:0] cur_e_q, prev_e_q;
    logic [X_W-1:0]    x_e_q;
    logic [Y_W-1:0]    y_e_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_e_q  <= '0;
            prev_e_q <= '0;
            x_e_q    <= '0;
            y_e_q    <= '0;
        end else if (pix_valid && !col_eff[0]) begin
            cur_e_q  <= pix_in;
            prev_e_q <= mem_rd;
            x_e_q    <= col_eff[CW-1:1];
            y_e_q    <= row_eff[RW-1:1];
        end
    end

    // ---------------------------------------------------------------
    // Pair sequencer. Quad coordinates are copied at the trigger because
    // an even accept during SECOND may already overwrite the even hold.
    // ---------------------------------------------------------------
    lb_state_t         state_q;
    logic [DATA_W-1:0] row_cur_q, row_prev_q, cur_o_q, prev_o_q;
    logic              pair_valid_q, done_q;
    logic [X_W-1:0]    qx_q;
    logic [Y_W-1:0]    qy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            row_cur_q    <= '0;
            row_prev_q   <= '0;
            pair_valid_q <= 1'b0;
            cur_o_q      <= '0;
            prev_o_q     <= '0;
            done_q       <= 1'b0;
            qx_q         <= '0;
            qy_q         <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (trigger) begin
                        row_cur_q    <= cur_e_q;
                        row_prev_q   <= prev_e_q;
                        pair_valid_q <= 1'b1;
                        cur_o_q      <= pix_in;
                        prev_o_q     <= mem_rd;
                        qx_q         <= x_e_q;
                        qy_q         <= y_e_q;
                        state_q      <= SECOND;
                    end else begin
                        pair_valid_q <= 1'b0;
                    end
                end
                SECOND: begin
                    row_cur_q    <= cur_o_q;
                    row_prev_q   <= prev_o_q;
                    pair_valid_q <= 1'b1;
                    done_q       <= 1'b1;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // One more stage so gs_valid lines up with the downstream registers
    // holding both pair halves.
    // ---------------------------------------------------------------
    logic           gs_valid_q;
    logic [X_W-1:0] gs_x_q;
    logic [Y_W-1:0] gs_y_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gs_valid_q <= 1'b0;
            gs_x_q     <= '0;
            gs_y_q     <= '0;
        end else begin
            gs_valid_q <= done_q;
            if (done_q) begin
                gs_x_q <= qx_q;
                gs_y_q <= qy_q;
            end
        end
    end

    assign row_cur    = row_cur_q;
    assign row_prev   = row_prev_q;
    assign pair_valid = pair_valid_q;
    assign gs_valid   = gs_valid_q;
    assign gs_x       = gs_x_q;
    assign gs_y       = gs_y_q;

endmodule : bayer_line_buffer

// File: tb/tb_bayer_line_buffer.sv
// Purpose     : self-checking bench for bayer_line_buffer with a 4-pixel line.
// Latency     : expects pairs at +0/+1 and gs_valid at +2 cycles after the odd-row/odd-col accept.
// Backpressure: none; the bench inserts random bubbles only.
module tb_bayer_line_buffer;

    localparam int DATA_W = 12;
    localparam int LINE_W = 4;
    localparam int X_W    = 1;
    localparam int Y_W    = 10;
    localparam int NROWS  = 2 ** (Y_W + 1);
    localparam int MAXC   = 8192;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] pix_in = '0;
    logic              pix_valid = 1'b0;
    logic              sof = 1'b0;
    logic [DATA_W-1:0] row_cur, row_prev;
    logic              pair_valid, gs_valid;
    logic [X_W-1:0]    gs_x;
    logic [Y_W-1:0]    gs_y;

    bayer_line_buffer #(
        .DATA_W (DATA_W),
        .LINE_W (LINE_W),
        .X_W    (X_W),
        .Y_W    (Y_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .row_cur    (row_cur),
        .row_prev   (row_prev),
        .pair_valid (pair_valid),
        .gs_valid   (gs_valid),
        .gs_x       (gs_x),
        .gs_y       (gs_y)
    );

    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc equals the number of posedges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream greyscale stage: free-running two-deep shift of (cur, prev).
    logic [DATA_W-1:0] g1c, g1p, g2c, g2p;
    logic [13:0]       gs_sum;
    always @(posedge clk) begin
        g1c <= row_cur;
        g1p <= row_prev;
        g2c <= g1c;
        g2p <= g1p;
    end
    assign gs_sum = 14'(g1c) + 14'(g1p) + 14'(g2c) + 14'(g2p);

    // Reference model: frame grid plus a per-cycle expectation schedule.
    int   frame [NROWS][LINE_W];
    int   m_col, m_row;
    bit   pv_e  [MAXC];
    int   cur_e [MAXC];
    int   prev_e[MAXC];
    bit   gs_e  [MAXC];
    int   gx_e  [MAXC];
    int   gy_e  [MAXC];
    int   ga_e  [MAXC];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic check_cycle();
        int n;
        n = cyc;
        check("pair_valid", 32'(pair_valid), 32'(pv_e[n]));
        if (pv_e[n]) begin
            check("row_cur", 32'(row_cur), 32'(cur_e[n]));
            check("row_prev", 32'(row_prev), 32'(prev_e[n]));
        end
        check("gs_valid", 32'(gs_valid), 32'(gs_e[n]));
        if (gs_e[n]) begin
            check("gs_x", 32'(gs_x), 32'(gx_e[n]));
            check("gs_y", 32'(gs_y), 32'(gy_e[n]));
            check("gs_out", 32'(gs_sum >> 2), 32'(ga_e[n]));
        end
    endtask

    task automatic model_accept(input bit s, input int p, input int k);
        int r, c;
        if (s) begin
            m_col = 0;
            m_row = 0;
        end
        frame[m_row][m_col] = p;
        r = m_row;
        c = m_col;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            pv_e[k]     = 1'b1;
            cur_e[k]    = frame[r][c-1];
            prev_e[k]   = frame[r-1][c-1];
            pv_e[k+1]   = 1'b1;
            cur_e[k+1]  = frame[r][c];
            prev_e[k+1] = frame[r-1][c];
            gs_e[k+2]   = 1'b1;
            gx_e[k+2]   = c / 2;
            gy_e[k+2]   = r / 2;
            ga_e[k+2]   = (frame[r][c-1] + frame[r-1][c-1] + frame[r][c] + frame[r-1][c]) / 4;
        end
        m_col++;
        if (m_col == LINE_W) begin
            m_col = 0;
            m_row = (m_row + 1) % NROWS;
        end
    endtask

    // Check this cycle's outputs, then present the next input.
    task automatic drive(input bit v, input bit s, input int p);
        @(negedge clk);
        check_cycle();
        pix_valid = v;
        sof       = s;
        pix_in    = p[DATA_W-1:0];
        if (v) model_accept(s, p, cyc + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_row_cur"}, 32'(row_cur), 32'd0);
        check({tag, "_row_prev"}, 32'(row_prev), 32'd0);
        check({tag, "_pair_valid"}, 32'(pair_valid), 32'd0);
        check({tag, "_gs_valid"}, 32'(gs_valid), 32'd0);
        check({tag, "_gs_x"}, 32'(gs_x), 32'd0);
        check({tag, "_gs_y"}, 32'(gs_y), 32'd0);
    endtask

    // Async reset pulse starting just after the edge that took the odd pixel.
    task automatic reset_mid();
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        sof       = 1'b0;
        #1;
        check_all_zero("mid_rst");
        for (int i = cyc; i < MAXC; i++) begin
            pv_e[i] = 1'b0;
            gs_e[i] = 1'b0;
        end
        m_col = 0;
        m_row = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int base_pix [8] = '{10, 20, 30, 40, 50, 60, 70, 80};

    initial begin
        for (int i = 0; i < MAXC; i++) begin
            pv_e[i] = 1'b0;
            gs_e[i] = 1'b0;
        end
        m_col = 0;
        m_row = 0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Two rows back-to-back.
        for (int i = 0; i < 8; i++) drive(1'b1, i == 0, base_pix[i]);
        idle(4);

        // Same data with a bubble between every pixel.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i == 0, base_pix[i]);
            drive(1'b0, 1'b0, 0);
        end
        idle(4);

        // Four-row frame, then a new frame.
        for (int i = 0; i < 16; i++) drive(1'b1, i == 0, int'($urandom_range(0, 4095)));
        for (int i = 0; i < 8; i++) drive(1'b1, i == 0, int'($urandom_range(0, 4095)));
        idle(4);

        // sof at col 2 of row 1, right behind a trigger (SECOND in flight).
        for (int i = 0; i < 6; i++) drive(1'b1, i == 0, int'($urandom_range(0, 4095)));
        for (int i = 0; i < 8; i++) drive(1'b1, i == 0, int'($urandom_range(0, 4095)));
        idle(4);

        // Reset during SECOND; following pixels restart at row 0 without sof.
        for (int i = 0; i < 6; i++) drive(1'b1, i == 0, int'($urandom_range(0, 4095)));
        reset_mid();
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, int'($urandom_range(0, 4095)));
        idle(4);

        // Saturated input.
        for (int i = 0; i < 8; i++) drive(1'b1, i == 0, 4095);
        idle(4);

        // Random stream with bubbles and occasional sof.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
                  int'($urandom_range(0, 4095)));
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_bayer_line_buffer

// File: doc/bayer_line_buffer.md
Name: bayer_line_buffer

Overview:
- Upstream feeder for the greyscale 2x2 averaging stage. Accepts a raster-order stream of 12-bit Bayer pixels from the sensor/capture path, one pixel per valid cycle.
- Stores one full line so each odd row can be paired with the row above it.
- For every completed 2x2 Bayer quad, drives the current-row and previous-row pixels on two back-to-back cycles. The greyscale stage's free-running shift registers then hold an aligned quad.
- Produces a window-valid strobe and quad coordinates, aligned to the greyscale output.

Parameters:
- DATA_W, 12, pixel width; must match the greyscale data width.
- LINE_W, 640, pixels per line; must be even, >= 4.
- X_W, $clog2(LINE_W/2), width of the quad column coordinate.
- Y_W, 10, width of the quad row coordinate.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, active-low.
- pix_in  in  DATA_W  incoming pixel.
- pix_valid  in  1  pix_in is accepted this cycle.
- sof  in  1  qualified by pix_valid; marks pixel (row 0, col 0) of a frame.
- row_cur  out  DATA_W  current-row pixel; drives greyscale data_in_1.
- row_prev  out  DATA_W  previous-row pixel, same column; drives greyscale data_in_2.
- pair_valid  out  1  row_cur/row_prev carry a quad pixel this cycle.
- gs_valid  out  1  greyscale gs_out holds a complete quad average this cycle.
- gs_x  out  X_W  quad column (col/2) for the gs_valid result.
- gs_y  out  Y_W  quad row (row/2) for the gs_valid result.

Behaviour:
- Clock and reset:
  - Single clock clk. Reset rst_n is asynchronous and active-low.
  - Reset values of all outputs, counters and state are 0; the state machine resets to IDLE.
  - Line memory is not reset; its contents are don't-care until row 0 has been written.
- Counters:
  - col (0..LINE_W-1) and row (0..2^(Y_W+1)-1) advance only on accepted pixels.
  - col wraps to 0 at LINE_W-1 and row increments on that wrap. row wraps silently at its maximum.
  - An accepted pixel with sof forces it to be col=0, row=0; counters then continue from (0, 1).
- Line memory:
  - LINE_W x DATA_W, indexed by col.
  - On every accept, mem[col] is read before it is written with pix_in, so the read returns the previous row.
- Even-column hold:
  - On accept with col even, pix_in and mem[col] are captured into the hold registers cur_e and prev_e.
  - The even-row/col coordinates are latched at the same time.
- State machine (IDLE, SECOND):
  - IDLE to SECOND: on accept with row odd and col odd.
    - At that same edge: row_cur <= cur_e, row_prev <= prev_e, pair_valid <= 1.
    - The odd pixel and its mem read are stored in cur_o/prev_o.
  - SECOND to IDLE: unconditionally on the next edge.
    - At that edge: row_cur <= cur_o, row_prev <= prev_o, pair_valid <= 1.
  - In IDLE with no trigger: pair_valid <= 0; row_cur/row_prev hold their value.
  - Accepts during SECOND are processed normally (counters, memory, even hold). A trigger cannot occur in SECOND because col is necessarily even.
- gs_valid timing:
  - gs_valid is the SECOND-exit pulse delayed one further cycle. It asserts 2 cycles after the triggering accept edge, for exactly one cycle.
  - That cycle is when the greyscale stage registers hold (odd, even) x (cur, prev).
  - gs_x = col/2 and gs_y = row>>1 of the trigger, registered alongside gs_valid.
- Throughput: one accept per cycle is sustained with no stalls. Input bubbles are allowed anywhere, including between the even and odd pixels of a pair.
- Boundary cases:
  - sof mid-line: counters restart and the even hold is overwritten by the next even pixel. A SECOND already in progress still completes, with its gs_valid.
  - Row 0 and all even rows: never produce pair_valid or gs_valid.
  - Reset mid-SECOND: the pulse is lost. The next pixel is treated as row 0, col 0 until the next sof.

Decomposition:
- Shared package img_pkg holds:
  - PIX_W = 12.
  - typedef pix_t (logic [PIX_W-1:0]).
  - Enum lb_state_t {IDLE, SECOND}.
- One sub-module, line_ram: a single-port LINE_W x DATA_W read-before-write memory with a combinational read. It infers distributed RAM or block RAM.

Test Plan:
- Bench configuration: LINE_W=4, rows 0 and 1 with pixels 10,20,30,40 / 50,60,70,80, back-to-back.
  - pair_valid pulses twice per pair: (row_cur, row_prev) = (50,10) then (60,20), followed by (70,30) then (80,40).
  - gs_valid pulses twice; greyscale gs_out = 35 with (gs_x, gs_y) = (0,0), then 55 with (1,0).
- Same data with one idle cycle inserted between every pixel: identical gs_out values and coordinates, and each gs_valid arrives exactly 2 cycles after the odd-column accept.
- Four-row frame, then sof on the next pixel: gs_y returns to 0, and the first quad of the new frame averages only new-frame data.
- sof asserted at col 2 of row 1 mid-frame: no gs_valid until the new row 1, col 1. The in-flight SECOND (if any) still emits its pulse.
- rst_n low for 1 cycle during SECOND: all outputs 0 immediately (asynchronously), no gs_valid afterwards. After release, the first quad appears only after a full row 0 plus row 1 pair.
- All-0xFFF input: gs_out = 0xFFF with no overflow, confirming the downstream 14-bit sum is sized correctly.
